// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, runtime baud divisor, parity and stop-bit options.
// Each frame uses the configuration latched when its word leaves the FIFO. Frames run back-to-back while words remain queued.
module uart_tx_fifo #(
    parameter int BITS_DATA = 8,
    parameter int FIFO_LOG2 = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic [BITS_DATA-1:0] axis_data,
    input  logic                 axis_valid,
    output logic                 axis_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [FIFO_LOG2:0]   fifo_level
);
    localparam int LVL_W = FIFO_LOG2 + 1;
    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [3:0]       LAST_BIT = 4'(BITS_DATA - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [BITS_DATA-1:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'b01:   p = ~(^data);
            2'b10:   p = ^data;
            2'b11:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    logic [BITS_DATA-1:0] mem_r [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_r;
    logic [FIFO_LOG2-1:0] rd_ptr_r;
    logic [LVL_W-1:0]     level_r;
    logic [LVL_W-1:0]     level_next_s;
    logic                 ready_r;
    logic                 busy_r;
    logic                 txd_r;

    state_t               state_r;
    state_t               state_next_s;
    logic [DIV_WIDTH-1:0] cnt_r;
    logic [3:0]           idx_r;
    logic [BITS_DATA-1:0] shift_r;
    logic [DIV_WIDTH-1:0] div_lat_r;
    logic [1:0]           par_lat_r;
    logic                 stop2_lat_r;
    logic                 par_bit_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 bit_end_s;
    logic                 tx_bit_s;
    logic [DIV_WIDTH-1:0] div_eff_s;
    logic [BITS_DATA-1:0] head_s;

    assign push_s    = axis_valid && ready_r;
    assign empty_s   = (level_r == {LVL_W{1'b0}});
    assign bit_end_s = (cnt_r == {DIV_WIDTH{1'b0}});
    assign head_s    = mem_r[rd_ptr_r];
    // A divisor of 0 would give a one-cycle bit; it is folded onto 1.
    assign div_eff_s = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : cfg_div;

    assign axis_ready = ready_r;
    assign txd        = txd_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;

    // FIFO level after this cycle's push/pop
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // FIFO storage; flushing is done through the pointers
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= axis_data;
        end
    end

    // FIFO pointers and level
    always_ff @(posedge sclk) begin
        if (reset) begin
            wr_ptr_r <= {FIFO_LOG2{1'b0}};
            rd_ptr_r <= {FIFO_LOG2{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_LOG2'(1);
            end
            level_r <= level_next_s;
        end
    end

    // Frame sequencing: next state and FIFO pop
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (idx_r == LAST_BIT)) begin
                    state_next_s = (par_lat_r != 2'b00) ? PARITY : STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                // idx_r == 0 on the first of two stop bits
                if (bit_end_s && !(stop2_lat_r && (idx_r == 4'd0))) begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Line level for the bit currently being timed
    always_comb begin
        tx_bit_s = 1'b1;
        case (state_r)
            IDLE:    tx_bit_s = 1'b1;
            START:   tx_bit_s = 1'b0;
            DATA:    tx_bit_s = shift_r[0];
            PARITY:  tx_bit_s = par_bit_r;
            STOP:    tx_bit_s = 1'b1;
            default: tx_bit_s = 1'b1;
        endcase
    end

    // State register, bit timer, shifter and per-frame configuration latch
    always_ff @(posedge sclk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {DIV_WIDTH{1'b0}};
            idx_r       <= 4'd0;
            shift_r     <= {BITS_DATA{1'b0}};
            div_lat_r   <= {DIV_WIDTH{1'b0}};
            par_lat_r   <= 2'b00;
            stop2_lat_r <= 1'b0;
            par_bit_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (pop_s) begin
                shift_r     <= head_s;
                div_lat_r   <= div_eff_s;
                par_lat_r   <= cfg_parity;
                stop2_lat_r <= cfg_stop2;
                par_bit_r   <= parity_bit(head_s, cfg_parity);
                cnt_r       <= div_eff_s;
                idx_r       <= 4'd0;
            end else if (bit_end_s && (state_r != IDLE)) begin
                cnt_r <= div_lat_r;
                if (state_r == DATA) begin
                    shift_r <= shift_r >> 1;
                    idx_r   <= (idx_r == LAST_BIT) ? 4'd0 : idx_r + 4'd1;
                end else if (state_r == STOP) begin
                    idx_r <= idx_r + 4'd1;
                end else begin
                    idx_r <= 4'd0;
                end
            end else if (state_r != IDLE) begin
                cnt_r <= cnt_r - DIV_WIDTH'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge sclk) begin
        if (reset) begin
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            txd_r   <= tx_bit_s;
            busy_r  <= (level_next_s != {LVL_W{1'b0}}) || (state_next_s != IDLE);
            ready_r <= (level_next_s != LVL_FULL);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: random words and configurations are compared against
// an expected txd waveform built from the frame format, plus FIFO fill, reset and latency scenarios.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int BD  = 8;
    localparam int FL  = 4;
    localparam int DW  = 16;
    localparam int BIG = 1 << 30;

    logic          sclk = 1'b0;
    logic          reset;
    logic [DW-1:0] cfg_div;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic [BD-1:0] axis_data;
    logic          axis_valid;
    logic          axis_ready;
    logic          txd;
    logic          busy;
    logic [FL:0]   fifo_level;

    int checks   = 0;
    int failures = 0;

    logic [7:0] words[$];
    logic       exp_txd[$];
    logic       cap_txd[$];
    logic       cap_busy[$];
    logic       cap_ready[$];
    int         cap_level[$];

    uart_tx_fifo #(.BITS_DATA(BD), .FIFO_LOG2(FL), .DIV_WIDTH(DW)) dut (
        .sclk(sclk), .reset(reset), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .axis_data(axis_data), .axis_valid(axis_valid),
        .axis_ready(axis_ready), .txd(txd), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 sclk = ~sclk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Appends the line levels of one frame, one entry per sclk cycle.
    task automatic add_frame(input logic [7:0] d, input int div, input logic [1:0] par,
                             input logic st2, output int len);
        int   per;
        logic odd_ones;
        logic bits[$];
        per      = (div < 2) ? 2 : div + 1;
        odd_ones = ($countones(d) % 2) == 1;
        bits.push_back(1'b0);
        for (int i = 0; i < BD; i++) bits.push_back(d[i]);
        if (par == 2'b01) bits.push_back(!odd_ones);
        else if (par == 2'b10) bits.push_back(odd_ones);
        else if (par == 2'b11) bits.push_back(1'b1);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (per) exp_txd.push_back(bits[i]);
        len = per * bits.size();
    endtask

    task automatic push_words(input int n, input int limit, output int acc);
        int   cyc;
        logic r;
        cyc = 0;
        acc = 0;
        while (acc < n && cyc < limit) begin
            axis_data  = words[acc];
            axis_valid = 1'b1;
            r = axis_ready;
            step();
            cyc++;
            if (r) acc++;
        end
        axis_valid = 1'b0;
    endtask

    task automatic capture(input int len, input int sw_idx, input int div_b);
        for (int s = 0; s < len; s++) begin
            step();
            cap_txd.push_back(txd);
            cap_busy.push_back(busy);
            cap_ready.push_back(axis_ready);
            cap_level.push_back(int'(fifo_level));
            if (s == sw_idx) cfg_div = DW'(div_b);
        end
    endtask

    task automatic clear_model();
        exp_txd.delete();
        cap_txd.delete();
        cap_busy.delete();
        cap_ready.delete();
        cap_level.delete();
    endtask

    // Sends words[0..n-1] into an idle block; cfg_div switches to div_b after sample sw.
    task automatic run_stream(input string name, input int n, input int div_a, input int div_b,
                              input int sw, input logic [1:0] par, input logic st2);
        int lat, len, total, acc, bad, busy_bad;
        cfg_div    = DW'(div_a);
        cfg_parity = par;
        cfg_stop2  = st2;
        clear_model();
        exp_txd.push_back(1'b1);
        exp_txd.push_back(1'b1);
        lat = 1;
        for (int k = 0; k < n; k++) begin
            add_frame(words[k], (lat > sw) ? div_b : div_a, par, st2, len);
            lat += len;
        end
        exp_txd.push_back(1'b1);
        total = exp_txd.size();
        fork
            push_words(n, 200, acc);
            capture(total, sw, div_b);
        join
        checks++;
        if (acc != n) begin
            failures++;
            $display("FAIL %s accepted: got %0d expected %0d", name, acc, n);
        end
        bad = -1;
        for (int i = 0; i < total; i++) if (bad < 0 && cap_txd[i] !== exp_txd[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s txd at cycle %0d: got %b expected %b", name, bad, cap_txd[bad], exp_txd[bad]);
        end
        busy_bad = 0;
        for (int i = 0; i <= total - 3; i++) if (cap_busy[i] !== 1'b1) busy_bad++;
        checks++;
        if (busy_bad != 0 || cap_busy[total-2] !== 1'b0 || cap_busy[total-1] !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: %0d low cycles in frame, end %b%b expected 00", name, busy_bad,
                     cap_busy[total-2], cap_busy[total-1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; axis_valid = 1'b0; axis_data = '0;
        cfg_div = DW'(9); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        repeat (3) step();
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (axis_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", axis_ready); end
        reset = 1'b0;
        step();
        checks++; if (axis_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b expected 1", axis_ready); end
    endtask

    task automatic test_8n1();
        words.delete(); words.push_back(8'hA5);
        run_stream("8n1_a5", 1, 9, 9, BIG, 2'b00, 1'b0);
    endtask

    task automatic test_parity();
        words.delete(); words.push_back(8'hA5);
        run_stream("even_a5", 1, 3, 3, BIG, 2'b10, 1'b0);
        run_stream("odd_a5", 1, 3, 3, BIG, 2'b01, 1'b0);
        run_stream("even_stop2_a5", 1, 3, 3, BIG, 2'b10, 1'b1);
        run_stream("mark_a5", 1, 3, 3, BIG, 2'b11, 1'b0);
    endtask

    task automatic test_small_div();
        words.delete(); words.push_back(8'h00);
        run_stream("div0_zero", 1, 0, 0, BIG, 2'b00, 1'b0);
        run_stream("div1_zero", 1, 1, 1, BIG, 2'b00, 1'b0);
    endtask

    task automatic test_cfg_change();
        words.delete();
        words.push_back(8'($urandom_range(0, 255)));
        words.push_back(8'($urandom_range(0, 255)));
        run_stream("div_change", 2, 9, 4, 30, 2'b00, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 5);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(8'($urandom_range(0, 255)));
            run_stream($sformatf("random_%0d", t), n, $urandom_range(0, 6), 0, BIG,
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_fill();
        int len, total, acc, bad, pop_at;
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(8'($urandom_range(0, 255)));
        cfg_div = DW'(99); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        clear_model();
        exp_txd.push_back(1'b1);
        exp_txd.push_back(1'b1);
        for (int k = 0; k < 17; k++) add_frame(words[k], 99, 2'b00, 1'b0, len);
        exp_txd.push_back(1'b1);
        total = exp_txd.size();
        fork
            push_words(20, 30, acc);
            capture(total, BIG, 0);
        join
        checks++;
        if (acc != 17) begin failures++; $display("FAIL fill_accepted: got %0d expected 17", acc); end
        checks++;
        if (cap_level[29] != 16 || cap_ready[29] !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: level %0d ready %b expected 16 0", cap_level[29], cap_ready[29]);
        end
        pop_at = -1;
        for (int i = 17; i < total; i++) if (pop_at < 0 && cap_level[i] < cap_level[i-1]) pop_at = i;
        checks++;
        if (pop_at != 1001) begin failures++; $display("FAIL fill_pop_cycle: got %0d expected 1001", pop_at); end
        checks++;
        if (pop_at < 1 || cap_ready[pop_at] !== 1'b1 || cap_ready[pop_at-1] !== 1'b0) begin
            failures++;
            $display("FAIL fill_ready_return: pop at %0d ready did not rise right after it", pop_at);
        end
        bad = -1;
        for (int i = 0; i < total; i++) if (bad < 0 && cap_txd[i] !== exp_txd[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL fill_txd at cycle %0d: got %b expected %b", bad, cap_txd[bad], exp_txd[bad]);
        end
        checks++;
        if (cap_busy[total-2] !== 1'b0 || cap_level[total-1] != 0) begin
            failures++;
            $display("FAIL fill_drain: busy %b level %0d expected 0 0", cap_busy[total-2], cap_level[total-1]);
        end
    endtask

    task automatic test_reset_mid();
        int acc, bad;
        words.delete();
        for (int i = 0; i < 6; i++) words.push_back(8'($urandom_range(0, 255)));
        cfg_div = DW'(9); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push_words(6, 20, acc);
        repeat (30) step();
        checks++;
        if (fifo_level != 5) begin failures++; $display("FAIL midreset_queued: got %0d expected 5", fifo_level); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (txd !== 1'b1 || fifo_level != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: txd %b level %0d busy %b expected 1 0 0", txd, fifo_level, busy);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midreset_quiet: %0d active cycles expected 0", bad); end
        words.delete(); words.push_back(8'($urandom_range(0, 255)));
        run_stream("after_reset", 1, 9, 9, BIG, 2'b00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_small_div();
        test_cfg_change();
        test_back_to_back();
        test_reset_mid();
        test_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Next-generation UART transmitter with runtime baud divisor, configurable parity and stop bits, and an input FIFO so software or DMA can queue bytes back-to-back. It sits between an AXI-Stream byte source on the bus clock and the board TXD pin. Frames are sent with no idle gap while the FIFO holds data. Configuration is sampled per frame.

Parameters:
BITS_DATA, 8, data bits per frame (5..9), sent LSB first
FIFO_LOG2, 4, FIFO depth = 2**FIFO_LOG2 words
DIV_WIDTH, 16, width of the baud divisor input

Ports:
sclk  in  1  bus clock; all logic on its rising edge
reset  in  1  synchronous, active-high
cfg_div  in  DIV_WIDTH  bit period in sclk cycles minus 1; values 0 and 1 are treated as 1
cfg_parity  in  2  00 none, 01 odd, 10 even, 11 mark (parity bit constant 1)
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
axis_data  in  BITS_DATA  byte to send
axis_valid  in  1  source valid
axis_ready  out  1  FIFO not full
txd  out  1  serial line, idle high, registered output
busy  out  1  FIFO non-empty or frame in progress
fifo_level  out  FIFO_LOG2+1  words held in FIFO, excluding the shifter

Behaviour:
- Reset values: txd=1, busy=0, fifo_level=0, axis_ready=0 while reset is high and 1 on the first cycle after. Reset flushes the FIFO, aborts any frame and returns the FSM to IDLE. Reset mid-frame drives txd=1 on the next edge.
- FIFO write on a beat where axis_valid&&axis_ready. axis_ready = (fifo_level != 2**FIFO_LOG2), registered and derived from the next-state level.
- Simultaneous push and pop while full: the pop frees a slot in the same cycle, but axis_ready reflects the registered level, so no push is accepted that cycle. Simultaneous push and pop otherwise leaves the level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop into the shifter and latch cfg_div, cfg_parity and cfg_stop2. Go to START on the next cycle. txd=1.
- Latency: a word accepted into an empty FIFO with the FSM idle at cycle N is popped at N+1, and txd falls at N+2.
- START: txd=0 for one bit period.
- DATA: BITS_DATA bits, LSB first, one bit period each.
- PARITY: entered only if latched parity != 00. Even parity bit = XOR of data bits; odd = its inverse; mark = 1.
- STOP: txd=1 for one bit period, or two if latched stop2=1.
- At the end of STOP: if the FIFO is non-empty, pop and enter START directly, with no idle cycle between the last stop bit and the next start bit. Otherwise go to IDLE.
- Bit timer: down-counter loaded with the latched divisor at every bit start; the bit ends when the count reaches 0. Bit period = latched_div+1 sclk cycles, exact with no accumulated drift.
- Config changes mid-frame have no effect until the next frame latch.
- busy = (fifo_level != 0) || state != IDLE. busy falls in the cycle the FSM re-enters IDLE with the FIFO empty.
- Frame length in sclk cycles = (div+1) * (1 + BITS_DATA + (parity?1:0) + (stop2?2:1)).

Test Plan:
- 8N1, cfg_div=9, push 0xA5 into idle block -> txd low 2 cycles after the accept beat. Bits held for 10 cycles each: 0,1,0,1,0,0,1,0,1,1. Total 100 cycles, then busy=0.
- cfg_parity=10 then 01, cfg_div=3, byte 0xA5 (four ones) -> parity bit 0 (even) / 1 (odd). Frame = 44 cycles. With cfg_stop2=1 the frame is 48 cycles and txd is high for the final 8 cycles.
- FIFO_LOG2=4, cfg_div=99, valid held high with 20 words -> 17 accepted (one moves to the shifter), then axis_ready=0 and fifo_level=16. ready returns exactly one cycle after the next pop. All 17 bytes are emitted back-to-back with no idle gap, in order.
- Change cfg_div from 9 to 4 mid-frame -> current frame keeps a 10-cycle bit period; next frame uses 5 cycles.
- Assert reset for one cycle during the third data bit with 5 words queued -> txd=1 and fifo_level=0 next cycle, busy=0, no further frames. A fresh push afterwards sends a correct full frame.
- cfg_div=0 and 1 -> both give a 2-cycle bit period; a frame of 0x00 in 8N1 has txd low for 18 cycles, then high for 2.
